// File: rtl/i2c_target_pkg.sv
// Shared FSM state encodings, bit-count and ACK constants for the I2C register target.
package i2c_target_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ADDR      = 4'd1;
  localparam state_t ST_ADDR_ACK  = 4'd2;
  localparam state_t ST_PTR       = 4'd3;
  localparam state_t ST_PTR_ACK   = 4'd4;
  localparam state_t ST_WDATA     = 4'd5;
  localparam state_t ST_WDATA_ACK = 4'd6;
  localparam state_t ST_RDATA     = 4'd7;
  localparam state_t ST_RDATA_ACK = 4'd8;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;
  localparam logic       ACK_LEVEL     = 1'b0;
  localparam logic       SDA_RELEASE   = 1'b1;
  localparam logic       SDA_DRIVE     = 1'b0;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_target_filter.sv
// Synchronizes SCL/SDA and derives edge and START/STOP strobes.
// Define I2C_TARGET_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronizers.
module i2c_target_filter
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_filt, sda_filt;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_prev_d = scl_filt;
    sda_prev_d = sda_filt;
  end

  // Idle bus is high, so presetting to 1 avoids spurious edges out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d;
  logic [1:0] sda_hist_q, sda_hist_d;
  logic       scl_maj_q, scl_maj_d;
  logic       sda_maj_q, sda_maj_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
    scl_maj_d  = majority3({scl_hist_q, scl_sync_q[1]});
    sda_maj_d  = majority3({sda_hist_q, sda_sync_q[1]});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_maj_q  <= 1'b1;
      sda_maj_q  <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_maj_q  <= scl_maj_d;
      sda_maj_q  <= sda_maj_d;
    end
  end

  assign scl_filt = scl_maj_q;
  assign sda_filt = sda_maj_q;
`else
  assign scl_filt = scl_sync_q[1];
  assign sda_filt = sda_sync_q[1];
`endif

  assign sda_lvl   = sda_filt;
  assign scl_rise  = scl_filt & ~scl_prev_q;
  assign scl_fall  = ~scl_filt & scl_prev_q;
  assign start_det = scl_filt & scl_prev_q & sda_prev_q & ~sda_filt;
  assign stop_det  = scl_filt & scl_prev_q & ~sda_prev_q & sda_filt;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a pointer-addressed register bank; no clock stretching.
// Define I2C_TARGET_GLITCH_FILTER_EN to enable the SCL/SDA majority glitch filter.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h20,
  parameter int         NUM_REGS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic                        sda_t,
  output logic [8*NUM_REGS-1:0]       regs_o,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy
);

  localparam int PTR_W = $clog2(NUM_REGS);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_target_filter u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               sda_t_q, sda_t_d;
  logic               rw_q, rw_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         regs_d [NUM_REGS];

  logic [7:0]         rx_byte;
  logic [7:0]         cur_byte;
  logic [7:0]         nxt_byte;
  logic [PTR_W-1:0]   ptr_inc;
  logic               last_bit;

  assign rx_byte  = {shift_q[6:0], sda_lvl};
  assign ptr_inc  = ptr_q + PTR_W'(1);
  assign cur_byte = regs_q[ptr_q];
  assign nxt_byte = regs_q[ptr_inc];
  assign last_bit = (bit_cnt_q == BITS_PER_BYTE - 4'd1);

  // Bus conditions take priority; otherwise bits shift on SCL rise and SDA moves on SCL fall
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_t_d     = sda_t_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_t_d   = SDA_RELEASE;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_t_d   = SDA_RELEASE;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d = ST_ADDR_ACK;
              sda_t_d = SDA_DRIVE;
              rw_d    = shift_q[0];
            end else begin
              state_d = ST_IDLE;
              sda_t_d = SDA_RELEASE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = ST_RDATA;
              sda_t_d = cur_byte[7];
              shift_d = {cur_byte[6:0], 1'b0};
            end else begin
              state_d = ST_PTR;
              sda_t_d = SDA_RELEASE;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              ptr_d = rx_byte[PTR_W-1:0];
            end
          end
          if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
            state_d = ST_PTR_ACK;
            sda_t_d = SDA_DRIVE;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = ST_WDATA;
            sda_t_d   = SDA_RELEASE;
            bit_cnt_d = '0;
          end
        end
        ST_WDATA: begin
          if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              regs_d[ptr_q] = rx_byte;
              wr_strobe_d   = 1'b1;
              wr_addr_d     = ptr_q;
              wr_data_d     = rx_byte;
              ptr_d         = ptr_inc;
            end
          end
          if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
            state_d = ST_WDATA_ACK;
            sda_t_d = SDA_DRIVE;
          end
        end
        ST_RDATA: begin
          if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall) begin
            if (bit_cnt_q == BITS_PER_BYTE) begin
              state_d = ST_RDATA_ACK;
              sda_t_d = SDA_RELEASE;
            end else begin
              sda_t_d = shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = sda_lvl;
          end
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (ack_q == ACK_LEVEL) begin
              state_d = ST_RDATA;
              ptr_d   = ptr_inc;
              sda_t_d = nxt_byte[7];
              shift_d = {nxt_byte[6:0], 1'b0};
            end else begin
              state_d = ST_IDLE;
              sda_t_d = SDA_RELEASE;
            end
          end
        end
        default: begin
          sda_t_d = SDA_RELEASE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_t_q     <= SDA_RELEASE;
      rw_q        <= 1'b0;
      ack_q       <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int n = 0; n < NUM_REGS; n++) begin
        regs_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_t_q     <= sda_t_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      regs_o[8*n +: 8] = regs_q[n];
    end
  end

  assign sda_o     = 1'b0;
  assign sda_t     = sda_t_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master with an open-drain SDA model.
// The glitch-rejection step only runs when I2C_TARGET_GLITCH_FILTER_EN is defined.
module tb_i2c_target;

  localparam int NUM_REGS = 16;
  localparam int Q        = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         scl_m = 1'b1;
  logic         sda_m = 1'b1;
  logic         sda_line;
  logic         sda_o, sda_t, wr_strobe, busy;
  logic [127:0] regs_o;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;

  int passed = 0;
  int total  = 0;
  int strobe_cnt = 0;
  int drive_cnt  = 0;
  logic [3:0] log_addr [$];
  logic [7:0] log_data [$];
  logic [7:0] exp_regs [NUM_REGS];

  always #5 clk = ~clk;

  assign sda_line = sda_t ? sda_m : (sda_m & sda_o);

  i2c_target #(.DEV_ADDR(7'h20), .NUM_REGS(NUM_REGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .regs_o    (regs_o),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // Record every write pulse and every clock the target pulls SDA low
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (!sda_t) drive_cnt++;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("[TB] FAIL watchdog: observed no finish, required finish within 200000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(master_ack);
  endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  task automatic write_bit_glitch(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    scl_m = 1'b0; wait_clk(1);
    scl_m = 1'b1; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask
`endif

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < NUM_REGS; n++) r[8*n +: 8] = exp_regs[n];
    return r;
  endfunction

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s0, d0;

    for (int n = 0; n < NUM_REGS; n++) exp_regs[n] = 8'h00;

    // Reset state
    rst_n = 1'b0;
    wait_clk(4);
    checkOutput("rst_sda_t", sda_t, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_strobe", wr_strobe, 1'b0);
    checkOutput("rst_wr_addr", wr_addr, 4'h0);
    checkOutput("rst_wr_data", wr_data, 8'h00);
    checkOutput("rst_regs", regs_o, model_flat());
    checkOutput("rst_sda_o", sda_o, 1'b0);
    rst_n = 1'b1;
    wait_clk(4);

    // Write A5,5A at pointer 3
    $display("[TB] write burst at pointer 3");
    i2c_start();
    checkOutput("w1_busy_on", busy, 1'b1);
    write_byte(8'h40, ack); checkOutput("w1_addr_ack", ack, 1'b0);
    write_byte(8'h03, ack); checkOutput("w1_ptr_ack", ack, 1'b0);
    write_byte(8'hA5, ack); checkOutput("w1_d0_ack", ack, 1'b0);
    write_byte(8'h5A, ack); checkOutput("w1_d1_ack", ack, 1'b0);
    i2c_stop();
    exp_regs[3] = 8'hA5;
    exp_regs[4] = 8'h5A;
    checkOutput("w1_busy_off", busy, 1'b0);
    checkOutput("w1_regs", regs_o, model_flat());
    checkOutput("w1_strobes", strobe_cnt, 2);
    checkOutput("w1_addr0", log_addr[0], 4'h3);
    checkOutput("w1_data0", log_data[0], 8'hA5);
    checkOutput("w1_addr1", log_addr[1], 4'h4);
    checkOutput("w1_data1", log_data[1], 8'h5A);

    // Foreign address: never acknowledged, nothing written
    $display("[TB] foreign address 0x21");
    s0 = strobe_cnt;
    d0 = drive_cnt;
    i2c_start();
    write_byte(8'h42, ack); checkOutput("na_addr_nack", ack, 1'b1);
    write_byte(8'h11, ack); checkOutput("na_data_nack", ack, 1'b1);
    i2c_stop();
    checkOutput("na_no_drive", drive_cnt - d0, 0);
    checkOutput("na_no_strobe", strobe_cnt - s0, 0);
    checkOutput("na_regs", regs_o, model_flat());

    // Set pointer, repeated START, read two bytes
    $display("[TB] read back through repeated start");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("rd_addr_ack", ack, 1'b0);
    write_byte(8'h03, ack); checkOutput("rd_ptr_ack", ack, 1'b0);
    i2c_start();
    checkOutput("rd_busy_sr", busy, 1'b1);
    write_byte(8'h41, ack); checkOutput("rd_raddr_ack", ack, 1'b0);
    read_byte(1'b0, rd);    checkOutput("rd_byte0", rd, 8'hA5);
    read_byte(1'b1, rd);    checkOutput("rd_byte1", rd, 8'h5A);
    checkOutput("rd_released", sda_t, 1'b1);
    i2c_stop();
    checkOutput("rd_busy_off", busy, 1'b0);
    checkOutput("rd_no_strobe", strobe_cnt, 2);

    // Pointer wrap 15 -> 0
    $display("[TB] pointer wrap");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("wr_addr_ack", ack, 1'b0);
    write_byte(8'h0F, ack); checkOutput("wr_ptr_ack", ack, 1'b0);
    write_byte(8'h11, ack); checkOutput("wr_d0_ack", ack, 1'b0);
    write_byte(8'h22, ack); checkOutput("wr_d1_ack", ack, 1'b0);
    i2c_stop();
    exp_regs[15] = 8'h11;
    exp_regs[0]  = 8'h22;
    checkOutput("wr_regs", regs_o, model_flat());
    checkOutput("wr_strobes", strobe_cnt, 4);
    checkOutput("wr_addr2", log_addr[2], 4'hF);
    checkOutput("wr_addr3", log_addr[3], 4'h0);

    // Partial byte then STOP: discarded
    $display("[TB] partial byte and mid-transaction reset");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("pb_addr_ack", ack, 1'b0);
    write_byte(8'h06, ack); checkOutput("pb_ptr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    checkOutput("pb_no_strobe", strobe_cnt, 4);
    checkOutput("pb_regs", regs_o, model_flat());

    // Reset while the target is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 6);
    checkOutput("mr_ack_driven", sda_t, 1'b0);
    rst_n = 1'b0;
    wait_clk(1);
    checkOutput("mr_sda_release", sda_t, 1'b1);
    wait_clk(2);
    rst_n = 1'b1;
    for (int n = 0; n < NUM_REGS; n++) exp_regs[n] = 8'h00;
    checkOutput("mr_busy", busy, 1'b0);
    checkOutput("mr_regs", regs_o, model_flat());
    read_bit(ack);          checkOutput("mr_ack_slot_free", ack, 1'b1);
    write_byte(8'h05, ack); checkOutput("mr_ignored", ack, 1'b1);
    i2c_stop();
    checkOutput("mr_no_strobe", strobe_cnt, 4);

    i2c_start();
    write_byte(8'h40, ack); checkOutput("ok_addr_ack", ack, 1'b0);
    write_byte(8'h06, ack); checkOutput("ok_ptr_ack", ack, 1'b0);
    write_byte(8'h77, ack); checkOutput("ok_d_ack", ack, 1'b0);
    i2c_stop();
    exp_regs[6] = 8'h77;
    checkOutput("ok_regs", regs_o, model_flat());
    checkOutput("ok_strobes", strobe_cnt, 5);
    checkOutput("ok_addr", log_addr[4], 4'h6);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // One-clock SCL low glitch inside a data bit must not add a bit
    $display("[TB] SCL glitch rejection");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("gl_addr_ack", ack, 1'b0);
    write_byte(8'h08, ack); checkOutput("gl_ptr_ack", ack, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      if (i == 5) write_bit_glitch(1'b1);
      else write_bit(i == 5 || i == 4 || i == 3 || i == 2);
    end
    read_bit(ack);          checkOutput("gl_d_ack", ack, 1'b0);
    i2c_stop();
    exp_regs[8] = 8'h3C;
    checkOutput("gl_regs", regs_o, model_flat());
    checkOutput("gl_strobes", strobe_cnt, 6);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
